// File: rtl/pdp8_opr_pkg.sv
// Shared types and constants for the PDP-8 Group 1 operate sequencer and its rotater.
package pdp8_opr_pkg;

  localparam int unsigned AC_W = 12;
  localparam int unsigned IR_W = 9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    CMP  = 3'd2,
    INC  = 3'd3,
    ROT  = 3'd4
  } state_t;

  // Positions within IR (instruction bits 3..11)
  localparam int unsigned IR_GRP = 8;
  localparam int unsigned IR_CLA = 7;
  localparam int unsigned IR_CLL = 6;
  localparam int unsigned IR_CMA = 5;
  localparam int unsigned IR_CML = 4;
  localparam int unsigned IR_RAR = 3;
  localparam int unsigned IR_RAL = 2;
  localparam int unsigned IR_TWO = 1;
  localparam int unsigned IR_IAC = 0;

  localparam logic [2:0] ROT_NOP = 3'b000;
  localparam logic [2:0] ROT_BSW = 3'b001;
  localparam logic [2:0] ROT_RAL = 3'b010;
  localparam logic [2:0] ROT_RTL = 3'b011;
  localparam logic [2:0] ROT_RAR = 3'b100;
  localparam logic [2:0] ROT_RTR = 3'b101;

  // Conflicting rotate directions collapse to a pass-through
  function automatic logic [2:0] rot_decode(input logic rar, input logic ral, input logic two);
    logic [2:0] op;
    op = ROT_NOP;
    if (rar && !ral)       op = two ? ROT_RTR : ROT_RAR;
    else if (ral && !rar)  op = two ? ROT_RTL : ROT_RAL;
    else if (!rar && !ral) op = two ? ROT_BSW : ROT_NOP;
    return op;
  endfunction

endpackage

// File: rtl/opr1_sequencer.sv
// PDP-8 Group 1 operate sequencer: owns AC/L and steps clear, complement, increment, rotate.
// Optional OPR1_SKIP_EN skips steps whose instruction bits are all zero.
module opr1_sequencer
  import pdp8_opr_pkg::*;
#(
  parameter logic [11:0] AC_RST = 12'o0000,
  parameter logic        L_RST  = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [8:0]  IR,
  input  logic        LD,
  input  logic [11:0] D_IN,
  input  logic        LD_L,
  output logic [2:0]  ROT_OP,
  output logic [11:0] ROT_AI,
  output logic        ROT_LI,
  output logic        ROT_OE,
  input  logic [11:0] ROT_AO,
  input  logic        ROT_LO,
  output logic [11:0] AC,
  output logic        L,
  output logic        BUSY,
  output logic        DONE
);

  state_t            state, state_nxt;
  logic [7:0]        ir_q;
  logic [7:0]        ir_eff;
  logic [AC_W-1:0]   ac_q;
  logic              l_q;
  logic [AC_W:0]     inc_sum;
  logic              accept;
  logic [2:0]        rot_op_q, rot_op_nxt;
  logic              rot_oe_q, rot_oe_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;

  // LD has priority over START; group-2 encodings are not ours to run
  assign accept  = (state == IDLE) && START && !LD && !IR[IR_GRP];
  assign ir_eff  = (state == IDLE) ? IR[7:0] : ir_q;
  assign inc_sum = {1'b0, ac_q} + (AC_W+1)'(1);

  // State register plus registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      rot_op_q <= ROT_NOP;
      rot_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      rot_op_q <= rot_op_nxt;
      rot_oe_q <= rot_oe_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

`ifdef OPR1_SKIP_EN
  logic need_clr, need_cmp, need_inc, need_rot;
  assign need_clr = ir_eff[IR_CLA] | ir_eff[IR_CLL];
  assign need_cmp = ir_eff[IR_CMA] | ir_eff[IR_CML];
  assign need_inc = ir_eff[IR_IAC];
  // An empty instruction still takes one pass-through ROT step
  assign need_rot = ir_eff[IR_RAR] | ir_eff[IR_RAL] | ir_eff[IR_TWO]
                  | !(need_clr | need_cmp | need_inc);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = need_clr ? CLR : need_cmp ? CMP : need_inc ? INC : ROT;
      CLR:  state_nxt = need_cmp ? CMP : need_inc ? INC : need_rot ? ROT : IDLE;
      CMP:  state_nxt = need_inc ? INC : need_rot ? ROT : IDLE;
      INC:  state_nxt = need_rot ? ROT : IDLE;
      ROT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
`else
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = CLR;
      CLR:  state_nxt = CMP;
      CMP:  state_nxt = INC;
      INC:  state_nxt = ROT;
      ROT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
`endif

  // Next values of the registered outputs, keyed on the state being entered
  always_comb begin
    rot_op_nxt = ROT_NOP;
    rot_oe_nxt = 1'b0;
    busy_nxt   = (state_nxt != IDLE);
    done_nxt   = (state != IDLE) && (state_nxt == IDLE);
    if (state_nxt == ROT) begin
      rot_oe_nxt = 1'b1;
      rot_op_nxt = rot_decode(ir_eff[IR_RAR], ir_eff[IR_RAL], ir_eff[IR_TWO]);
    end
  end

  // AC/L datapath and instruction latch
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ac_q <= AC_RST;
      l_q  <= L_RST;
      ir_q <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (LD) begin
            ac_q <= D_IN;
            l_q  <= LD_L;
          end else if (accept) begin
            ir_q <= IR[7:0];
          end
        end
        CLR: begin
          if (ir_q[IR_CLA]) ac_q <= '0;
          if (ir_q[IR_CLL]) l_q  <= 1'b0;
        end
        CMP: begin
          if (ir_q[IR_CMA]) ac_q <= ~ac_q;
          if (ir_q[IR_CML]) l_q  <= ~l_q;
        end
        INC: begin
          if (ir_q[IR_IAC]) begin
            ac_q <= inc_sum[AC_W-1:0];
            l_q  <= l_q ^ inc_sum[AC_W];
          end
        end
        ROT: begin
          ac_q <= ROT_AO;
          l_q  <= ROT_LO;
        end
        default: begin
          ac_q <= ac_q;
        end
      endcase
    end
  end

  assign ROT_OP = rot_op_q;
  assign ROT_OE = rot_oe_q;
  assign ROT_AI = ac_q;
  assign ROT_LI = l_q;
  assign AC     = ac_q;
  assign L      = l_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_opr1_sequencer.sv
// Directed bench for opr1_sequencer with a behavioural rotater on the ROT_* ports.
module tb_opr1_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [8:0]  IR;
  logic        LD;
  logic [11:0] D_IN;
  logic        LD_L;
  logic [2:0]  ROT_OP;
  logic [11:0] ROT_AI;
  logic        ROT_LI;
  logic        ROT_OE;
  logic [11:0] ROT_AO;
  logic        ROT_LO;
  logic [11:0] AC;
  logic        L;
  logic        BUSY;
  logic        DONE;

  int total = 0;
  int bad   = 0;

  opr1_sequencer dut (
    .CLK(CLK), .RESET(RESET), .START(START), .IR(IR), .LD(LD), .D_IN(D_IN), .LD_L(LD_L),
    .ROT_OP(ROT_OP), .ROT_AI(ROT_AI), .ROT_LI(ROT_LI), .ROT_OE(ROT_OE),
    .ROT_AO(ROT_AO), .ROT_LO(ROT_LO), .AC(AC), .L(L), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Rotater: rotates the 13-bit {L,AC} word, or swaps AC halves
  always_comb begin
    logic [11:0] a;
    logic        li;
    a  = ROT_AI;
    li = ROT_LI;
    case (ROT_OP)
      3'b010:  {ROT_LO, ROT_AO} = {a, li};
      3'b011:  {ROT_LO, ROT_AO} = {a[10:0], li, a[11]};
      3'b100:  {ROT_LO, ROT_AO} = {a[0], li, a[11:1]};
      3'b101:  {ROT_LO, ROT_AO} = {a[1], a[0], li, a[11:2]};
      3'b001:  {ROT_LO, ROT_AO} = {li, a[5:0], a[11:6]};
      default: {ROT_LO, ROT_AO} = {li, a};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [11:0] d, input logic l);
    @(negedge CLK);
    LD = 1'b1; D_IN = d; LD_L = l;
    @(negedge CLK);
    LD = 1'b0;
    chk("load_ac", AC, d);
    chk("load_l", L, l);
  endtask

  // Issue one START and check every step up to the trailing cycle after DONE
  task automatic run_seq(input logic [8:0] ir, input logic [11:0] a1, input logic [11:0] a2,
                         input logic [11:0] a3, input logic [2:0] op, input logic [11:0] af,
                         input logic lf, input bit spam);
    logic [11:0] amid [1:3];
    amid[1] = a1; amid[2] = a2; amid[3] = a3;
    @(negedge CLK);
    IR = ir; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0; IR = 9'o017;
    chk("busy_e0", BUSY, 1);
    chk("oe_e0", ROT_OE, 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (k < 4) begin
        chk($sformatf("busy_e%0d", k), BUSY, 1);
        chk($sformatf("done_e%0d", k), DONE, 0);
        chk($sformatf("ac_e%0d", k), AC, amid[k]);
        chk($sformatf("oe_e%0d", k), ROT_OE, (k == 3) ? 1 : 0);
        chk($sformatf("op_e%0d", k), ROT_OP, (k == 3) ? op : 3'b000);
      end else begin
        chk("done_e4", DONE, 1);
        chk("busy_e4", BUSY, 0);
        chk("ac_final", AC, af);
        chk("l_final", L, lf);
        chk("oe_e4", ROT_OE, 0);
        chk("op_e4", ROT_OP, 0);
      end
      if (spam && k == 1) begin START = 1'b1; IR = 9'o240; end
      if (k == 3) START = 1'b0;
    end
    @(posedge CLK);
    @(negedge CLK);
    chk("done_after", DONE, 0);
    chk("busy_after", BUSY, 0);
    chk("ac_hold", AC, af);
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; IR = '0; LD = 1'b0; D_IN = '0; LD_L = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ac", AC, 12'o0000);
    chk("rst_l", L, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_oe", ROT_OE, 0);
    chk("rst_op", ROT_OP, 0);
    RESET = 1'b0;

    // IAC wrap at 7777
    do_load(12'o7777, 1'b0);
    run_seq(9'o001, 12'o7777, 12'o7777, 12'o0000, 3'b000, 12'o0000, 1'b1, 1'b0);
    // CLA CMA, L untouched
    do_load(12'o1234, 1'b1);
    run_seq(9'o240, 12'o0000, 12'o7777, 12'o7777, 3'b000, 12'o7777, 1'b1, 1'b0);
    // RAL moves AC11 into L
    do_load(12'o4000, 1'b0);
    run_seq(9'o004, 12'o4000, 12'o4000, 12'o4000, 3'b010, 12'o0000, 1'b1, 1'b0);
    // BSW
    do_load(12'o0077, 1'b1);
    run_seq(9'o002, 12'o0077, 12'o0077, 12'o0077, 3'b001, 12'o7700, 1'b1, 1'b0);
    // CLA RAL BSW IAC with a second START during BUSY
    do_load(12'o1234, 1'b0);
    run_seq(9'o207, 12'o0000, 12'o0000, 12'o0001, 3'b011, 12'o0004, 1'b0, 1'b1);

    // Group bit set: ignored
    @(negedge CLK);
    START = 1'b1; IR = 9'o401;
    @(negedge CLK);
    START = 1'b0;
    chk("grp_busy", BUSY, 0);
    chk("grp_ac", AC, 12'o0004);

    // LD and START together: LD wins
    @(negedge CLK);
    START = 1'b1; IR = 9'o001; LD = 1'b1; D_IN = 12'o5555; LD_L = 1'b1;
    @(negedge CLK);
    START = 1'b0; LD = 1'b0;
    chk("ldst_ac", AC, 12'o5555);
    chk("ldst_l", L, 1);
    chk("ldst_busy", BUSY, 0);
    @(negedge CLK);
    chk("ldst_busy2", BUSY, 0);

    // Reset during INC step
    do_load(12'o1234, 1'b1);
    @(negedge CLK);
    START = 1'b1; IR = 9'o001;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_rst_busy", BUSY, 1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("mid_rst_ac", AC, 12'o0000);
    chk("mid_rst_l", L, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_oe", ROT_OE, 0);
    chk("mid_rst_done", DONE, 0);
    @(negedge CLK);
    chk("mid_rst_done2", DONE, 0);
    chk("mid_rst_ac2", AC, 12'o0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opr1_sequencer.md
Name: opr1_sequencer

Overview:
- Executes PDP-8 Group 1 operate microinstructions (CLA, CLL, CMA, CML, IAC, RAR, RAL, RTR, RTL, BSW) on the AC and Link registers.
- Owns the AC/L state and steps through the four PDP-8 event times in order: clear, complement, increment, rotate.
- Sits directly upstream of the rotater. It drives the rotater's OP, AI, LI and OE, and captures the rotater's AO and LO in the rotate step.

Parameters:
- AC_RST, 12'o0000, AC value after reset.
- L_RST, 1'b0, Link value after reset.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  one-cycle request to execute the microinstruction in IR.
- IR  input  9  instruction bits 3..11: [8]=group (must be 0), [7]=CLA, [6]=CLL, [5]=CMA, [4]=CML, [3]=RAR, [2]=RAL, [1]=BSW/two, [0]=IAC.
- LD  input  1  load AC from D_IN and L from LD_L.
- D_IN  input  12  AC load data.
- LD_L  input  1  Link load data.
- ROT_OP  output  3  rotater opcode.
- ROT_AI  output  12  current AC, to the rotater.
- ROT_LI  output  1  current L, to the rotater.
- ROT_OE  output  1  rotater output enable.
- ROT_AO  input  12  rotater AC result.
- ROT_LO  input  1  rotater Link result.
- AC  output  12  accumulator register.
- L  output  1  Link register.
- BUSY  output  1  high while a sequence is in progress.
- DONE  output  1  one-cycle pulse when AC/L hold the final result.

Behaviour:
- Reset: AC=AC_RST, L=L_RST, state=IDLE, BUSY=0, DONE=0, ROT_OE=0, ROT_OP=000. Reset overrides a sequence in progress; no partial result completes.
- IR is latched on START acceptance. Later changes to IR do not affect the sequence in flight.
- States and transitions: IDLE -> CLR -> CMP -> INC -> ROT -> IDLE. Each state lasts one cycle.
- Latency: START accepted at edge 0. AC/L updates occur at edges 1, 2, 3 and 4 (CLR, CMP, INC, ROT steps). DONE is high in the cycle after edge 4; BUSY is high from edge 0 until edge 4.
- CLR step: CLA sets AC to 0; CLL sets L to 0.
- CMP step: CMA sets AC to ~AC; CML sets L to ~L.
- INC step: IAC sets AC to AC+1 modulo 4096. A carry out of bit 11 complements L. At 7777 the AC wraps to 0000 and L toggles.
- ROT step: ROT_OE=1 and ROT_OP is decoded from the latched IR. AC takes ROT_AO and L takes ROT_LO.
- ROT_OP decode:
  - RAR&!RAL gives 100, or 101 when IR[1] is set.
  - RAL&!RAR gives 010, or 011 when IR[1] is set.
  - Neither RAR nor RAL, with IR[1] set, gives 001 (BSW).
  - Anything else, including RAR&RAL together, gives 000 (pass-through).
- ROT_OE is 0 and ROT_OP is 000 in every state other than ROT.
- ROT_AI and ROT_LI always reflect the AC and L registers.
- START while BUSY is ignored.
- START with IR[8]=1 is ignored and the block stays IDLE.
- LD is accepted only in IDLE.
- LD and START in the same IDLE cycle: LD wins and START is dropped.

Optional Feature:
- Macro: OPR1_SKIP_EN.
- Defined: a step whose IR bits are all zero is skipped (IDLE goes to the next required state). Latency becomes 1 to 4 cycles. An instruction with no functional bits set completes in one cycle via a single ROT pass-through step.
- Undefined: fixed 4-cycle latency as specified above.

Decomposition:
- Package pdp8_opr_pkg holds:
  - the state enum (IDLE, CLR, CMP, INC, ROT);
  - IR bit index constants;
  - rotater opcode constants ROT_NOP=000, ROT_BSW=001, ROT_RAL=010, ROT_RTL=011, ROT_RAR=100, ROT_RTR=101.
- No sub-module. The rotater is instantiated by the parent and wired to the ROT_* ports.

Test Plan:
- AC=7777, L=0, START with IR=001 (IAC) -> DONE one cycle after edge 4; AC=0000, L=1; ROT_OP=000 throughout.
- LD D_IN=1234, then START with IR=240 (CLA CMA) -> AC=7777, L unchanged.
- LD D_IN=4000, LD_L=0, then START with IR=004 (RAL) -> ROT_OE=1 and ROT_OP=010 in the ROT cycle only; final AC=0000, L=1.
- AC=0077, L=1, START with IR=002 (BSW) -> ROT_OP=001; final AC=7700, L=1.
- AC=1234, START with IR=207 (CLA RAL BSW IAC) -> AC goes 0000, then 0001, then RTL gives 0004, L=0. A second START issued during BUSY is ignored.
- RESET asserted in the INC cycle -> the next cycle has AC=AC_RST, L=L_RST, BUSY=0, and no DONE pulse.
